// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encodings and
// default bus widths matching the core's memory-address and instruction buses.
package if_prefetch_unit_pkg;

    localparam int unsigned IF_ADDR_W = 32;
    localparam int unsigned IF_INST_W = 32;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bundles the redirect input, unified memory read port and decode-side
// output port of the prefetch unit, plus its debug view (occupancy, FSM state).
interface if_prefetch_unit_if
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W,
    parameter int unsigned INST_W = IF_INST_W,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Handshakes: a memory request transfers on an edge where mem_req && mem_gnt,
    // and mem_addr is held while mem_req=1; mem_rvalid returns one word per
    // transfer with no back-pressure; decode pops on an edge where
    // out_valid && out_ready, and the head is held while out_valid=1 and not popped.
    logic              br;
    logic [ADDR_W-1:0] br_target;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CW-1:0]     occupancy;
    if_state_e         dbg_state;

    modport master (
        input  br, br_target, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_inst, occupancy, dbg_state
    );

    modport slave (
        output br, br_target, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_inst, occupancy, dbg_state
    );

endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush; the head entry is read straight from
// registered storage so there is no input-to-output combinational path.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[PW'(i)] <= '0;
            end
        end else if (flush) begin
            // Flush wins over any same-cycle push or pop.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: fetches sequentially ahead of decode into a small
// FIFO, one memory request in flight, with branch redirect and stale-response discard.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W     = IF_ADDR_W,
    parameter int unsigned       INST_W     = IF_INST_W,
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic                clk,
    input logic                rst,
    if_prefetch_unit_if.master bus
);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned FW  = ADDR_W + INST_W;

    if_state_e         state;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic              discard;

    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head;
    logic              pop;
    logic              push;
    logic [CW1-1:0]    count_after;
    logic              room_after;

    assign pop  = !empty && bus.out_ready;
    // mem_addr_q still holds the address of the request being answered.
    assign push = (state == IF_WAIT) && bus.mem_rvalid && !discard && !bus.br;

    always_comb begin
        count_after = {1'b0, count};
        if (push) count_after = count_after + CW1'(1);
        if (pop)  count_after = count_after - CW1'(1);
    end

    assign room_after = (count_after < CW1'(DEPTH));

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push && !full),
        .push_data ({mem_addr_q, bus.mem_rdata}),
        .pop       (pop),
        .flush     (bus.br),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IF_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
        end else begin
            unique case (state)
                IF_IDLE: begin
                    // With nothing in flight the credit check reduces to occupancy alone.
                    if (bus.br) begin
                        fetch_pc <= bus.br_target;
                    end else if (count < CW'(DEPTH)) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc;
                        state      <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state     <= IF_WAIT;
                        discard   <= bus.br;
                        fetch_pc  <= bus.br ? bus.br_target : fetch_pc + ADDR_W'(INST_BYTES);
                    end else if (bus.br) begin
                        mem_req_q <= 1'b0;
                        state     <= IF_IDLE;
                        fetch_pc  <= bus.br_target;
                    end
                end
                IF_WAIT: begin
                    if (bus.br) begin
                        fetch_pc <= bus.br_target;
                    end
                    if (bus.mem_rvalid) begin
                        discard <= 1'b0;
                        // Chain the next fetch immediately when the push leaves room.
                        if (push && room_after) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc;
                            state      <= IF_REQ;
                        end else begin
                            state <= IF_IDLE;
                        end
                    end else if (bus.br) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state     <= IF_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = head[FW-1:INST_W];
    assign bus.out_inst  = head[INST_W-1:0];
    assign bus.occupancy = count;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: a small memory responder model plus one
// task per scenario, each comparing DUT outputs against hand-derived values.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] MAGIC  = 32'hA5A5_5A5A;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_w = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    if_prefetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) m ();
    if_prefetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) w ();

    if_prefetch_unit #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .INST_BYTES(4), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    if_prefetch_unit #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .INST_BYTES(4), .RESET_PC(32'hFFFF_FFFC)
    ) dut_wrap (
        .clk (clk),
        .rst (rst_w),
        .bus (w)
    );

    // Memory model for the main DUT
    int          gnt_block     = 0;
    int          rsp_delay     = 0;
    logic        rsp_arm       = 1'b0;
    int          rsp_cnt       = 0;
    logic [31:0] rsp_addr      = '0;
    logic        use_override  = 1'b0;
    logic [31:0] override_data = '0;
    int          grant_cnt     = 0;
    logic [31:0] last_grant    = '0;
    logic [31:0] gnt_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && m.mem_req === 1'b1 && m.mem_gnt === 1'b1) begin
            rsp_arm  = 1'b1;
            rsp_cnt  = rsp_delay;
            rsp_addr = m.mem_addr;
            grant_cnt++;
            last_grant = m.mem_addr;
            gnt_q.push_back(m.mem_addr);
        end
    end

    always @(negedge clk) begin
        m.mem_rvalid = 1'b0;
        if (rst) begin
            rsp_arm = 1'b0;
        end else if (rsp_arm) begin
            if (rsp_cnt == 0) begin
                m.mem_rvalid = 1'b1;
                m.mem_rdata  = use_override ? override_data : (rsp_addr ^ MAGIC);
                use_override = 1'b0;
                rsp_arm      = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        m.mem_gnt = (gnt_block == 0);
        if (gnt_block > 0) gnt_block--;
    end

    // Memory model for the wrap-around DUT: always grants, answers one cycle later
    logic        w_arm  = 1'b0;
    logic [31:0] w_addr = '0;

    always @(posedge clk) begin
        if (!rst_w && w.mem_req === 1'b1 && w.mem_gnt === 1'b1) begin
            w_arm  = 1'b1;
            w_addr = w.mem_addr;
        end
    end

    always @(negedge clk) begin
        w.mem_gnt    = 1'b1;
        w.mem_rvalid = w_arm;
        w.mem_rdata  = w_addr ^ MAGIC;
        w_arm        = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst asserted after three edges; the caller releases it.
    task automatic do_reset();
        rst          = 1'b1;
        m.br         = 1'b0;
        m.br_target  = '0;
        m.out_ready  = 1'b1;
        gnt_block    = 0;
        rsp_delay    = 0;
        use_override = 1'b0;
        repeat (3) tick();
        grant_cnt = 0;
        gnt_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (m.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", m.mem_req); end
        checks++;
        if (m.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 00000000", m.mem_addr); end
        checks++;
        if (m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", m.out_valid); end
        checks++;
        if (m.out_pc !== 32'h0 || m.out_inst !== 32'h0) begin
            errors++; $display("FAIL reset_out_data got pc=%h inst=%h want 0/0", m.out_pc, m.out_inst);
        end
        checks++;
        if (m.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", m.occupancy); end
        checks++;
        if (m.dbg_state !== IF_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", m.dbg_state); end
        checks++;
        if (w.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_wrap_addr got %h want fffffffc", w.mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] got;
        logic [31:0] want;
        logic        want_v;
        int          pops;
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        rst  = 1'b0;
        pops = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c <= 3) begin
                want_v = (c == 3);
                checks++;
                if (m.out_valid !== want_v) begin
                    errors++; $display("FAIL seq_first_valid cycle %0d got %b want %b", c, m.out_valid, want_v);
                end
            end
            if (m.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL seq_extra_pop got pc=%h want none", m.out_pc);
                end else begin
                    want = exp_q.pop_front();
                    if (m.out_pc !== want || m.out_inst !== (want ^ MAGIC)) begin
                        errors++;
                        $display("FAIL seq_pop got pc=%h inst=%h want pc=%h inst=%h", m.out_pc, m.out_inst, want, want ^ MAGIC);
                    end
                end
                pops++;
            end
        end
        checks++;
        if (pops < 10) begin errors++; $display("FAIL seq_pop_count got %0d want >=10", pops); end
        checks++;
        if (gnt_q.size() < 10) begin errors++; $display("FAIL seq_grant_count got %0d want >=10", gnt_q.size()); end
        want = 32'h0;
        while (gnt_q.size() > 0) begin
            got = gnt_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL seq_grant_addr got %h want %h", got, want); end
            want = want + 32'd4;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m.out_ready = 1'b0;
        rst = 1'b0;
        repeat (25) tick();
        checks++;
        if (grant_cnt != 4) begin errors++; $display("FAIL bp_grants got %0d want 4", grant_cnt); end
        checks++;
        if (m.mem_req !== 1'b0 || m.occupancy !== 3'd4) begin
            errors++; $display("FAIL bp_full got req=%b occ=%0d want req=0 occ=4", m.mem_req, m.occupancy);
        end
        checks++;
        if (m.out_pc !== 32'h0 || m.out_inst !== MAGIC) begin
            errors++; $display("FAIL bp_head got pc=%h inst=%h want pc=0 inst=%h", m.out_pc, m.out_inst, MAGIC);
        end
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
        checks++;
        if (m.occupancy !== 3'd3 || m.out_pc !== 32'h4) begin
            errors++; $display("FAIL bp_one_pop got occ=%0d pc=%h want occ=3 pc=4", m.occupancy, m.out_pc);
        end
        repeat (8) tick();
        checks++;
        if (grant_cnt != 5 || last_grant !== 32'h10) begin
            errors++; $display("FAIL bp_refill got grants=%0d addr=%h want 5 / 00000010", grant_cnt, last_grant);
        end
        checks++;
        if (m.mem_req !== 1'b0 || m.occupancy !== 3'd4) begin
            errors++; $display("FAIL bp_refull got req=%b occ=%0d want req=0 occ=4", m.mem_req, m.occupancy);
        end
    endtask

    task automatic test_branch_wait();
        logic seen;
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 40 && !(m.mem_req === 1'b1 && m.mem_addr === 32'h8); c++) tick();
        checks++;
        if (!(m.mem_req === 1'b1 && m.mem_addr === 32'h8)) begin
            errors++; $display("FAIL brw_reach_req8 got req=%b addr=%h want 1 / 00000008", m.mem_req, m.mem_addr);
        end
        rsp_delay     = 2;
        override_data = 32'hDEAD_BEEF;
        use_override  = 1'b1;
        tick();
        checks++;
        if (m.dbg_state !== IF_WAIT || last_grant !== 32'h8) begin
            errors++; $display("FAIL brw_in_wait got state=%0d addr=%h want WAIT / 00000008", m.dbg_state, last_grant);
        end
        m.br = 1'b1;
        m.br_target = 32'h100;
        tick();
        m.br = 1'b0;
        rsp_delay = 0;
        checks++;
        if (m.occupancy !== 3'd0 || m.out_valid !== 1'b0) begin
            errors++; $display("FAIL brw_flush got occ=%0d valid=%b want 0/0", m.occupancy, m.out_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && m.out_valid !== 1'b1; c++) begin
            if (m.mem_req === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (m.mem_addr !== 32'h100 || use_override) begin
                    errors++; $display("FAIL brw_next_req got addr=%h stale_pending=%b want 00000100 / 0", m.mem_addr, use_override);
                end
            end
            tick();
        end
        checks++;
        if (m.out_valid !== 1'b1 || m.out_pc !== 32'h100 || m.out_inst !== (32'h100 ^ MAGIC)) begin
            errors++; $display("FAIL brw_first_out got v=%b pc=%h inst=%h want 1 / 00000100 / %h",
                               m.out_valid, m.out_pc, m.out_inst, 32'h100 ^ MAGIC);
        end
    endtask

    task automatic test_branch_rvalid_pop();
        do_reset();
        m.out_ready = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 40 && !(m.dbg_state === IF_WAIT && m.occupancy === 3'd2); c++) tick();
        checks++;
        if (m.dbg_state !== IF_WAIT || m.occupancy !== 3'd2) begin
            errors++; $display("FAIL brr_setup got state=%0d occ=%0d want WAIT / 2", m.dbg_state, m.occupancy);
        end
        m.br = 1'b1;
        m.br_target = 32'h100;
        m.out_ready = 1'b1;
        tick();
        m.br = 1'b0;
        checks++;
        if (m.occupancy !== 3'd0 || m.out_valid !== 1'b0 || m.dbg_state !== IF_IDLE) begin
            errors++; $display("FAIL brr_flush got occ=%0d valid=%b state=%0d want 0 / 0 / IDLE",
                               m.occupancy, m.out_valid, m.dbg_state);
        end
        for (int c = 0; c < 20 && m.out_valid !== 1'b1; c++) tick();
        checks++;
        if (m.out_valid !== 1'b1 || m.out_pc !== 32'h100 || m.out_inst !== (32'h100 ^ MAGIC)) begin
            errors++; $display("FAIL brr_first_out got v=%b pc=%h inst=%h want 1 / 00000100 / %h",
                               m.out_valid, m.out_pc, m.out_inst, 32'h100 ^ MAGIC);
        end
    endtask

    task automatic test_back_to_back_br();
        do_reset();
        rsp_delay     = 3;
        override_data = 32'hDEAD_BEEF;
        use_override  = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 10 && m.dbg_state !== IF_WAIT; c++) tick();
        rsp_delay = 0;
        m.br = 1'b1;
        m.br_target = 32'h200;
        tick();
        m.br_target = 32'h300;
        tick();
        m.br = 1'b0;
        for (int c = 0; c < 20 && m.out_valid !== 1'b1; c++) tick();
        checks++;
        if (m.out_pc !== 32'h300 || m.out_inst !== (32'h300 ^ MAGIC)) begin
            errors++; $display("FAIL b2b_first_out got pc=%h inst=%h want 00000300 / %h", m.out_pc, m.out_inst, 32'h300 ^ MAGIC);
        end
        checks++;
        if (grant_cnt != 2 || last_grant !== 32'h300) begin
            errors++; $display("FAIL b2b_grants got n=%0d last=%h want 2 / 00000300", grant_cnt, last_grant);
        end
    endtask

    task automatic test_gnt_stall_and_reset();
        do_reset();
        rst = 1'b0;
        tick();
        gnt_block = 5;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (m.mem_req !== 1'b1 || m.mem_addr !== 32'h0 || m.dbg_state !== IF_REQ || grant_cnt != 0) begin
                errors++; $display("FAIL stall_hold cycle %0d got req=%b addr=%h state=%0d grants=%0d want 1 / 0 / REQ / 0",
                                   c, m.mem_req, m.mem_addr, m.dbg_state, grant_cnt);
            end
        end
        tick();
        checks++;
        if (grant_cnt != 1 || m.mem_req !== 1'b0 || m.dbg_state !== IF_WAIT) begin
            errors++; $display("FAIL stall_grant got grants=%0d req=%b state=%0d want 1 / 0 / WAIT",
                               grant_cnt, m.mem_req, m.dbg_state);
        end
        rsp_delay = 3;
        tick();
        checks++;
        if (m.mem_req !== 1'b1 || m.mem_addr !== 32'h4) begin
            errors++; $display("FAIL stall_next_addr got req=%b addr=%h want 1 / 00000004", m.mem_req, m.mem_addr);
        end
        tick();
        checks++;
        if (m.dbg_state !== IF_WAIT || last_grant !== 32'h4) begin
            errors++; $display("FAIL stall_wait4 got state=%0d addr=%h want WAIT / 00000004", m.dbg_state, last_grant);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (m.mem_req !== 1'b0 || m.mem_addr !== 32'h0 || m.out_valid !== 1'b0 || m.occupancy !== 3'd0 ||
            m.out_pc !== 32'h0 || m.out_inst !== 32'h0 || m.dbg_state !== IF_IDLE) begin
            errors++; $display("FAIL midwait_reset got req=%b addr=%h v=%b occ=%0d pc=%h inst=%h state=%0d want all zero / IDLE",
                               m.mem_req, m.mem_addr, m.out_valid, m.occupancy, m.out_pc, m.out_inst, m.dbg_state);
        end
        tick();
        rsp_delay = 0;
        rst = 1'b0;
        tick();
        checks++;
        if (m.mem_req !== 1'b1 || m.mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req got req=%b addr=%h want 1 / 00000000", m.mem_req, m.mem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        rst_w = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            tick();
            if (w.out_valid === 1'b1) begin
                want = exp_q.pop_front();
                checks++;
                if (w.out_pc !== want || w.out_inst !== (want ^ MAGIC)) begin
                    errors++; $display("FAIL wrap_pop got pc=%h inst=%h want pc=%h inst=%h", w.out_pc, w.out_inst, want, want ^ MAGIC);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        m.br = 1'b0;  m.br_target = '0;  m.out_ready = 1'b1;
        m.mem_gnt = 1'b1;  m.mem_rvalid = 1'b0;  m.mem_rdata = '0;
        w.br = 1'b0;  w.br_target = '0;  w.out_ready = 1'b1;
        w.mem_gnt = 1'b1;  w.mem_rvalid = 1'b0;  w.mem_rdata = '0;

        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_wait();
        test_branch_rvalid_pop();
        test_back_to_back_br();
        test_gnt_stall_and_reset();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
